// File: rtl/led_s2p_rx_pkg.sv
// led_s2p_rx_pkg: shared FSM encoding and synchronizer depth for the LED serial receiver.
package led_s2p_rx_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/led_s2p_rx_sync_edge.sv
// sync_edge: multi-flop synchronizer with a history flop for rising-edge detection.
module sync_edge
  import led_s2p_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync,
  output logic rise
);
  logic [SYNC_STAGES-1:0] ff;
  logic prev;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ff <= '0;
      prev <= 1'b0;
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], d};
      prev <= ff[SYNC_STAGES-1];
    end
  assign sync = ff[SYNC_STAGES-1];
  assign rise = sync & ~prev;
endmodule

// File: rtl/led_s2p_rx.sv
// led_s2p_rx: oversampling serial-to-parallel receiver for the four-wire LED shift interface.
module led_s2p_rx
  import led_s2p_rx_pkg::*;
#(
  parameter int DATA_BITS = 16,
  parameter int DATA_COUNT_BITS = 4,
  parameter bit INVERT_DATA = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_clk,
  input  logic                 s_data,
  input  logic                 s_clrn,
  input  logic                 s_pen,
  output logic [DATA_BITS-1:0] PData,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);
  localparam logic [DATA_COUNT_BITS:0] FULL_CNT = DATA_BITS[DATA_COUNT_BITS:0];
  logic clk_sync, clk_rise, pen_sync, pen_rise, data_sync, data_rise, clrn_sync, clrn_rise;
  logic unused_sync;
  logic sbit, frame_ok;
  logic [DATA_BITS-1:0] shift_reg, shift_nx;
  logic [DATA_COUNT_BITS:0] cnt, cnt_nx;
  state_t state, state_nx;
  sync_edge u_clk  (.clk(clk), .rst(rst), .d(s_clk),  .sync(clk_sync),  .rise(clk_rise));
  sync_edge u_pen  (.clk(clk), .rst(rst), .d(s_pen),  .sync(pen_sync),  .rise(pen_rise));
  sync_edge u_data (.clk(clk), .rst(rst), .d(s_data), .sync(data_sync), .rise(data_rise));
  sync_edge u_clrn (.clk(clk), .rst(rst), .d(s_clrn), .sync(clrn_sync), .rise(clrn_rise));
  assign unused_sync = ^{clk_sync, pen_sync, data_rise, clrn_rise};
  // Shift and count first so a coincident s_pen edge judges the updated count.
  always_comb begin
    sbit = data_sync ^ INVERT_DATA;
    shift_nx = clk_rise ? {shift_reg[DATA_BITS-2:0], sbit} : shift_reg;
    cnt_nx = (clk_rise && state != FULL) ? cnt + 1'b1 : cnt;
    frame_ok = cnt_nx == FULL_CNT;
    state_nx = pen_rise ? IDLE : frame_ok ? FULL : (cnt_nx != '0) ? SHIFT : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      shift_reg <= '0;
      cnt <= '0;
      state <= IDLE;
      PData <= '0;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else if (!clrn_sync) begin
      shift_reg <= '0;
      cnt <= '0;
      state <= IDLE;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      shift_reg <= shift_nx;
      cnt <= pen_rise ? '0 : cnt_nx;
      state <= state_nx;
      PData <= (pen_rise && frame_ok) ? shift_nx : PData;
      data_valid <= pen_rise && frame_ok;
      frame_err <= pen_rise && !frame_ok;
      busy <= !pen_rise && cnt_nx != '0;
    end
endmodule
